// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg
// Shared definitions for the hazard/forwarding unit. It holds the MDU tracker
// state encoding, the register-address constants, the "no forwarding" select
// value, and two small helpers used by the top level.
package hazard_forward_unit_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam int FWD_RF = 0;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // A stage forwards to an operand only when it writes a real (non-x0) register
    // that the operand reads.
    function automatic logic fwd_hit(input logic we,
                                     input logic [REG_W-1:0] addr,
                                     input logic [REG_W-1:0] src);
        return we && (addr != REG_ZERO) && (addr == src);
    endfunction

    // Saturating 32-bit event counter step.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        logic [31:0] result;
        if (en && (value != 32'hFFFF_FFFF)) begin
            result = value + 32'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if
// Bundles the pipeline-side signals of hazard_forward_unit.
//   master: the pipeline (drives ID/EX/forwarding/MDU inputs, reads the results)
//   slave : hazard_forward_unit
// Inputs : id_src, id_is_mdu, ex_src, ex_mem_read, ex_write_reg, fwd_we,
//          fwd_addr, mdu_start, mdu_dst
// Outputs: fwd_sel, stall_id, bubble_ex, mdu_busy, mdu_done, mdu_wr_addr
//          and, with HAZARD_STATS_EN defined, stat_stall_cycles, stat_loaduse,
//          stat_fwd.
interface hazard_forward_unit_if
    import hazard_forward_unit_pkg::*;
#(
    parameter int N_SRC      = 2,
    parameter int FWD_STAGES = 2
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic [N_SRC*REG_W-1:0]      id_src;
    logic                        id_is_mdu;
    logic [N_SRC*REG_W-1:0]      ex_src;
    logic                        ex_mem_read;
    logic [REG_W-1:0]            ex_write_reg;
    logic [FWD_STAGES-1:0]       fwd_we;
    logic [FWD_STAGES*REG_W-1:0] fwd_addr;
    logic                        mdu_start;
    logic [REG_W-1:0]            mdu_dst;
    logic [N_SRC*SEL_W-1:0]      fwd_sel;
    logic                        stall_id;
    logic                        bubble_ex;
    logic                        mdu_busy;
    logic                        mdu_done;
    logic [REG_W-1:0]            mdu_wr_addr;
`ifdef HAZARD_STATS_EN
    logic [31:0]                 stat_stall_cycles;
    logic [31:0]                 stat_loaduse;
    logic [31:0]                 stat_fwd;

    modport master (
        output id_src, id_is_mdu, ex_src, ex_mem_read, ex_write_reg,
               fwd_we, fwd_addr, mdu_start, mdu_dst,
        input  fwd_sel, stall_id, bubble_ex, mdu_busy, mdu_done, mdu_wr_addr,
               stat_stall_cycles, stat_loaduse, stat_fwd
    );
    modport slave (
        input  id_src, id_is_mdu, ex_src, ex_mem_read, ex_write_reg,
               fwd_we, fwd_addr, mdu_start, mdu_dst,
        output fwd_sel, stall_id, bubble_ex, mdu_busy, mdu_done, mdu_wr_addr,
               stat_stall_cycles, stat_loaduse, stat_fwd
    );
`else
    modport master (
        output id_src, id_is_mdu, ex_src, ex_mem_read, ex_write_reg,
               fwd_we, fwd_addr, mdu_start, mdu_dst,
        input  fwd_sel, stall_id, bubble_ex, mdu_busy, mdu_done, mdu_wr_addr
    );
    modport slave (
        input  id_src, id_is_mdu, ex_src, ex_mem_read, ex_write_reg,
               fwd_we, fwd_addr, mdu_start, mdu_dst,
        output fwd_sel, stall_id, bubble_ex, mdu_busy, mdu_done, mdu_wr_addr
    );
`endif

endinterface

// File: rtl/hazard_forward_unit_mdu_tracker.sv
// mdu_tracker
// Follows one in-flight multi-cycle MUL/DIV operation.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   mdu_start    EX starts an MDU op (ignored unless idle)
//   mdu_dst      destination register of the starting op
//   mdu_busy     tracker not idle (BUSY or DONE)
//   mdu_done     one-cycle result-valid pulse
//   mdu_wr_addr  destination paired with mdu_done, zero otherwise
//   dst_q        latched destination of the in-flight op
// mdu_done rises MDU_LAT cycles after the start edge: MDU_LAT-1 BUSY cycles
// (counter loaded with MDU_LAT-2 and run down to zero) followed by one DONE
// cycle. The 3-bit counter limits MDU_LAT to the range 2..9.
module mdu_tracker
    import hazard_forward_unit_pkg::*;
#(
    parameter int MDU_LAT = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             mdu_start,
    input  logic [REG_W-1:0] mdu_dst,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [REG_W-1:0] mdu_wr_addr,
    output logic [REG_W-1:0] dst_q
);
    localparam logic [2:0] CNT_LOAD = 3'(MDU_LAT - 2);

    mdu_state_e       state_r;
    mdu_state_e       state_nxt_s;
    logic [2:0]       cnt_r;
    logic [2:0]       cnt_nxt_s;
    logic [REG_W-1:0] dst_r;
    logic [REG_W-1:0] dst_nxt_s;

    // State, countdown and destination registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MDU_IDLE;
            cnt_r   <= 3'd0;
            dst_r   <= REG_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dst_r   <= dst_nxt_s;
        end
    end

    // Next-state logic; a start outside IDLE is simply not looked at.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        dst_nxt_s   = dst_r;
        case (state_r)
            MDU_IDLE: begin
                if (mdu_start) begin
                    state_nxt_s = MDU_BUSY;
                    cnt_nxt_s   = CNT_LOAD;
                    dst_nxt_s   = mdu_dst;
                end else begin
                    state_nxt_s = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                if (cnt_r == 3'd0) begin
                    state_nxt_s = MDU_DONE;
                end else begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            MDU_DONE: begin
                state_nxt_s = MDU_IDLE;
            end
            default: begin
                state_nxt_s = MDU_IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // Outputs are forced low while reset is held so an aborted op never
    // shows a completion.
    assign mdu_busy    = !reset && (state_r != MDU_IDLE);
    assign mdu_done    = !reset && (state_r == MDU_DONE);
    assign mdu_wr_addr = mdu_done ? dst_r : REG_ZERO;
    assign dst_q       = dst_r;

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// EX-stage operand forwarding, load-use detection and MDU hazard tracking.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    hazard_forward_unit_if.slave carrying the ID/EX/forwarding/MDU
//          inputs and fwd_sel, stall_id, bubble_ex, mdu_busy, mdu_done,
//          mdu_wr_addr outputs.
// Optional: define HAZARD_STATS_EN to add saturating 32-bit counters
// stat_stall_cycles, stat_loaduse and stat_fwd on the interface.
// fwd_sel per operand: 0 = register file, k = forwarding stage k (1 = MEM).
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int N_SRC      = 2,
    parameter int FWD_STAGES = 2,
    parameter int MDU_LAT    = 4
)(
    input logic                  clk,
    input logic                  reset,
    hazard_forward_unit_if.slave bus
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic             mdu_busy_s;
    logic [REG_W-1:0] dst_q_s;
    logic             load_use_s;
    logic             mdu_raw_s;
    logic             mdu_struct_s;
    logic             stall_s;

    mdu_tracker #(
        .MDU_LAT(MDU_LAT)
    ) u_mdu_tracker (
        .clk        (clk),
        .reset      (reset),
        .mdu_start  (bus.mdu_start),
        .mdu_dst    (bus.mdu_dst),
        .mdu_busy   (mdu_busy_s),
        .mdu_done   (bus.mdu_done),
        .mdu_wr_addr(bus.mdu_wr_addr),
        .dst_q      (dst_q_s)
    );

    assign bus.mdu_busy = mdu_busy_s;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_fwd
        logic [SEL_W-1:0] sel_s;

        // Priority encoder: scanning from the farthest stage inwards lets the
        // nearest matching stage overwrite any older one.
        always_comb begin
            sel_s = SEL_W'(FWD_RF);
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (fwd_hit(bus.fwd_we[k-1],
                            bus.fwd_addr[(k-1)*REG_W +: REG_W],
                            bus.ex_src[gi*REG_W +: REG_W])) begin
                    sel_s = SEL_W'(k);
                end else begin
                    sel_s = sel_s;
                end
            end
        end

        assign bus.fwd_sel[gi*SEL_W +: SEL_W] = sel_s;
    end

    // Load-use and MDU read-after-write detection across all ID operands.
    always_comb begin
        load_use_s = 1'b0;
        mdu_raw_s  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!reset && bus.ex_mem_read && (bus.ex_write_reg != REG_ZERO) &&
                (bus.id_src[i*REG_W +: REG_W] == bus.ex_write_reg)) begin
                load_use_s = 1'b1;
            end else begin
                load_use_s = load_use_s;
            end
            if (mdu_busy_s && (dst_q_s != REG_ZERO) &&
                (bus.id_src[i*REG_W +: REG_W] == dst_q_s)) begin
                mdu_raw_s = 1'b1;
            end else begin
                mdu_raw_s = mdu_raw_s;
            end
        end
    end

    // Only one MDU op may be in flight, so any MDU op in ID waits.
    assign mdu_struct_s  = bus.id_is_mdu && mdu_busy_s;
    assign stall_s       = load_use_s || mdu_raw_s || mdu_struct_s;
    assign bus.stall_id  = stall_s;
    assign bus.bubble_ex = stall_s;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] loaduse_cnt_r;
    logic [31:0] fwd_cnt_r;
    logic        fwd_any_s;

    assign fwd_any_s = |bus.fwd_sel;

    // Saturating event counters sampled every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r   <= 32'd0;
            loaduse_cnt_r <= 32'd0;
            fwd_cnt_r     <= 32'd0;
        end else begin
            stall_cnt_r   <= sat_inc(stall_cnt_r, stall_s);
            loaduse_cnt_r <= sat_inc(loaduse_cnt_r, load_use_s);
            fwd_cnt_r     <= sat_inc(fwd_cnt_r, fwd_any_s);
        end
    end

    assign bus.stat_stall_cycles = stall_cnt_r;
    assign bus.stat_loaduse      = loaduse_cnt_r;
    assign bus.stat_fwd          = fwd_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
// Directed stimulus for hazard_forward_unit with a cycle-level reference model
// (MDU tracked as "cycles since start") compared on every falling edge, plus
// literal expectations at key points of each scenario.
module tb_hazard_forward_unit;
    localparam int N_SRC      = 2;
    localparam int FWD_STAGES = 2;
    localparam int MDU_LAT    = 4;
    localparam int SEL_W      = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    hazard_forward_unit_if #(.N_SRC(N_SRC), .FWD_STAGES(FWD_STAGES)) bus ();

    hazard_forward_unit #(
        .N_SRC(N_SRC), .FWD_STAGES(FWD_STAGES), .MDU_LAT(MDU_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit         m_active  = 1'b0;
    int         m_elapsed = 0;
    logic [4:0] m_dst     = 5'd0;
    int         m_stall   = 0;
    int         m_lu      = 0;
    int         m_fwd     = 0;

    function automatic int exp_sel(input int i);
        for (int k = 1; k <= FWD_STAGES; k++) begin
            if (bus.fwd_we[k-1] && bus.fwd_addr[(k-1)*5 +: 5] != 5'd0 &&
                bus.fwd_addr[(k-1)*5 +: 5] == bus.ex_src[i*5 +: 5])
                return k;
        end
        return 0;
    endfunction

    function automatic logic [N_SRC*SEL_W-1:0] exp_fwd();
        logic [N_SRC*SEL_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_SRC; i++) v[i*SEL_W +: SEL_W] = SEL_W'(exp_sel(i));
        return v;
    endfunction

    function automatic bit id_reads(input logic [4:0] r);
        for (int i = 0; i < N_SRC; i++) if (bus.id_src[i*5 +: 5] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_busy();
        return !reset && m_active;
    endfunction

    function automatic bit exp_done();
        return exp_busy() && (m_elapsed == MDU_LAT);
    endfunction

    function automatic bit exp_loaduse();
        return !reset && bus.ex_mem_read && bus.ex_write_reg != 5'd0 && id_reads(bus.ex_write_reg);
    endfunction

    function automatic bit exp_stall();
        bit raw;
        bit strc;
        raw  = exp_busy() && m_dst != 5'd0 && id_reads(m_dst);
        strc = exp_busy() && bus.id_is_mdu;
        return exp_loaduse() || raw || strc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance on each active edge.
    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0;
            m_stall  <= 0;
            m_lu     <= 0;
            m_fwd    <= 0;
        end else begin
            if (exp_stall()) m_stall <= m_stall + 1;
            if (exp_loaduse()) m_lu <= m_lu + 1;
            if (exp_fwd() != '0) m_fwd <= m_fwd + 1;
            if (m_active) begin
                if (m_elapsed == MDU_LAT) m_active <= 1'b0;
                else m_elapsed <= m_elapsed + 1;
            end else if (bus.mdu_start) begin
                m_active  <= 1'b1;
                m_elapsed <= 1;
                m_dst     <= bus.mdu_dst;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("fwd_sel", 32'(bus.fwd_sel), 32'(exp_fwd()));
        check("stall_id", 32'(bus.stall_id), 32'(exp_stall()));
        check("bubble_ex", 32'(bus.bubble_ex), 32'(exp_stall()));
        check("mdu_busy", 32'(bus.mdu_busy), 32'(exp_busy()));
        check("mdu_done", 32'(bus.mdu_done), 32'(exp_done()));
        check("mdu_wr_addr", 32'(bus.mdu_wr_addr), exp_done() ? 32'(m_dst) : 32'd0);
`ifdef HAZARD_STATS_EN
        check("stat_stall_cycles", bus.stat_stall_cycles, 32'(m_stall));
        check("stat_loaduse", bus.stat_loaduse, 32'(m_lu));
        check("stat_fwd", bus.stat_fwd, 32'(m_fwd));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.id_src       = 10'd0;
        bus.id_is_mdu    = 1'b0;
        bus.ex_src       = 10'd0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_write_reg = 5'd0;
        bus.fwd_we       = 2'b00;
        bus.fwd_addr     = 10'd0;
        bus.mdu_start    = 1'b0;
        bus.mdu_dst      = 5'd0;
        reset            = 1'b1;
        cyc();
        cyc();
        neg();
        check("rst_busy", 32'(bus.mdu_busy), 32'd0);
        check("rst_done", 32'(bus.mdu_done), 32'd0);
        check("rst_stall", 32'(bus.stall_id), 32'd0);
        cyc();
        reset = 1'b0;

        // Forwarding priority.
        bus.ex_src = {5'd0, 5'd5}; bus.fwd_we = 2'b11; bus.fwd_addr = {5'd5, 5'd5};
        neg(); check("fwd_both_stage1", 32'(bus.fwd_sel[1:0]), 32'd1);
        cyc(); bus.fwd_we = 2'b10;
        neg(); check("fwd_stage2_only", 32'(bus.fwd_sel[1:0]), 32'd2);
        cyc(); bus.fwd_we = 2'b11; bus.fwd_addr = {5'd0, 5'd0};
        neg(); check("fwd_addr_zero", 32'(bus.fwd_sel[1:0]), 32'd0);
        cyc(); bus.ex_src = {5'd7, 5'd5}; bus.fwd_addr = {5'd7, 5'd5};
        neg(); check("fwd_two_ops", 32'(bus.fwd_sel), 32'd9);
        cyc(); bus.fwd_we = 2'b00; bus.fwd_addr = 10'd0; bus.ex_src = 10'd0;

        // Load-use.
        bus.ex_mem_read = 1'b1; bus.ex_write_reg = 5'd8; bus.id_src = {5'd8, 5'd3};
        neg(); check("lu_stall", 32'(bus.stall_id), 32'd1);
        check("lu_bubble", 32'(bus.bubble_ex), 32'd1);
        cyc(); bus.ex_mem_read = 1'b0;
        neg(); check("lu_released", 32'(bus.stall_id), 32'd0);
        cyc(); bus.ex_mem_read = 1'b1; bus.ex_write_reg = 5'd0; bus.id_src = 10'd0;
        neg(); check("lu_x0_no_stall", 32'(bus.stall_id), 32'd0);
        cyc(); bus.ex_mem_read = 1'b0;

        // MDU latency, RAW and structural stalls.
        bus.mdu_start = 1'b1; bus.mdu_dst = 5'd9;
        neg(); check("mdu_t_busy", 32'(bus.mdu_busy), 32'd0);
        cyc(); bus.mdu_start = 1'b0; bus.id_src = {5'd0, 5'd9};
        neg(); check("mdu_t1_busy", 32'(bus.mdu_busy), 32'd1);
        check("mdu_t1_raw", 32'(bus.stall_id), 32'd1);
        check("mdu_t1_done", 32'(bus.mdu_done), 32'd0);
        cyc();
        neg(); check("mdu_t2_done", 32'(bus.mdu_done), 32'd0);
        cyc(); bus.id_src = 10'd0; bus.id_is_mdu = 1'b1;
        neg(); check("mdu_t3_struct", 32'(bus.stall_id), 32'd1);
        check("mdu_t3_done", 32'(bus.mdu_done), 32'd0);
        cyc(); bus.id_is_mdu = 1'b0; bus.id_src = {5'd0, 5'd9};
        neg(); check("mdu_t4_done", 32'(bus.mdu_done), 32'd1);
        check("mdu_t4_wr", 32'(bus.mdu_wr_addr), 32'd9);
        check("mdu_t4_raw", 32'(bus.stall_id), 32'd1);
        cyc();
        neg(); check("mdu_t5_busy", 32'(bus.mdu_busy), 32'd0);
        check("mdu_t5_stall", 32'(bus.stall_id), 32'd0);
        check("mdu_t5_done", 32'(bus.mdu_done), 32'd0);
`ifdef HAZARD_STATS_EN
        cyc(); neg();
        check("stat_loaduse_lit", bus.stat_loaduse, 32'd1);
        check("stat_stall_lit", bus.stat_stall_cycles, 32'd5);
        check("stat_fwd_lit", bus.stat_fwd, 32'd3);
`endif
        cyc(); bus.id_src = 10'd0;

        // Reset mid-operation.
        bus.mdu_start = 1'b1; bus.mdu_dst = 5'd12;
        cyc(); bus.mdu_start = 1'b0;
        cyc(); reset = 1'b1;
        neg(); check("abort_busy", 32'(bus.mdu_busy), 32'd0);
        cyc(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            neg(); check("abort_no_done", 32'(bus.mdu_done), 32'd0);
            check("abort_idle", 32'(bus.mdu_busy), 32'd0);
            cyc();
        end

        // Fresh op completes; a start while busy is ignored.
        bus.mdu_start = 1'b1; bus.mdu_dst = 5'd3;
        cyc(); bus.mdu_start = 1'b0;
        cyc(); bus.mdu_start = 1'b1; bus.mdu_dst = 5'd20;
        cyc(); bus.mdu_start = 1'b0;
        cyc();
        neg(); check("restart_done", 32'(bus.mdu_done), 32'd1);
        check("restart_wr", 32'(bus.mdu_wr_addr), 32'd3);
        cyc();
        neg(); check("restart_idle", 32'(bus.mdu_busy), 32'd0);
        cyc();

        // Start coinciding with reset loses.
        reset = 1'b1; bus.mdu_start = 1'b1; bus.mdu_dst = 5'd7;
        cyc(); reset = 1'b0; bus.mdu_start = 1'b0;
        neg(); check("rst_wins", 32'(bus.mdu_busy), 32'd0);
        cyc();

        // dst 0: sequences without raising a RAW stall.
        bus.mdu_start = 1'b1; bus.mdu_dst = 5'd0;
        cyc(); bus.mdu_start = 1'b0; bus.id_src = 10'd0;
        neg(); check("x0_busy", 32'(bus.mdu_busy), 32'd1);
        check("x0_no_stall", 32'(bus.stall_id), 32'd0);
        repeat (5) cyc();
        neg(); check("x0_idle", 32'(bus.mdu_busy), 32'd0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
